id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 47 ++++
 rtl/load_use_detect.sv | 21 ++
 rtl/id_ex_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX control-bundle layout: bit offsets as defines for the decoder and EX stage,
// mirrored here as localparams and a packed struct for SystemVerilog users.
`ifndef ID_EX_DEFINES_SVH
`define ID_EX_DEFINES_SVH
`define CTRL_W          25
`define CTRL_RS1USE     24
`define CTRL_RS2USE     23
`define CTRL_BRTYPE_LO  20
`define CTRL_JAL        19
`define CTRL_JALR       18
`define CTRL_IMMSEL_LO  14
`define CTRL_ALUSRCA    13
`define CTRL_ALUSRCB    12
`define CTRL_ALUCTRL_LO 8
`define CTRL_MEMRD_LO   5
`define CTRL_MEMWR_LO   3
`define CTRL_MEMRW      2
`define CTRL_REGWRITE   1
`define CTRL_MEM2REG    0
`define CNT_W_DEFAULT   32
`endif

package id_ex_stage_pkg;
  localparam int CTRL_W       = `CTRL_W;
  localparam int CNT_W_DEF    = `CNT_W_DEFAULT;
  localparam int CTRL_RS1USE  = `CTRL_RS1USE;
  localparam int CTRL_RS2USE  = `CTRL_RS2USE;
  localparam int CTRL_REGWRITE = `CTRL_REGWRITE;
  localparam int CTRL_MEM2REG = `CTRL_MEM2REG;

  typedef struct packed {
    logic       rs1_use;
    logic       rs2_use;
    logic [2:0] br_type;
    logic       jal;
    logic       jalr;
    logic [3:0] imm_sel;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [3:0] alu_ctrl;
    logic [2:0] mem_rd_ctrl;
    logic [1:0] mem_wr_ctrl;
    logic       mem_rw;
    logic       reg_write;
    logic       mem2reg;
  } ctrl_t;
endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: ID source register matches the destination of a load in EX.
module load_use_detect (
  input  logic       id_valid,
  input  logic       rs1_use,
  input  logic       rs2_use,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       ex_valid,
  input  logic       ex_mem2reg,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_rd,
  output logic       hz
);
  logic rs1_hit, rs2_hit;

  assign rs1_hit = rs1_use && (rs1 == ex_rd);
  assign rs2_hit = rs2_use && (rs2 == ex_rd);
  // x0 never carries a loaded value, so a load to x0 cannot cause a stall
  assign hz = id_valid && ex_valid && ex_mem2reg && ex_regwrite &&
              (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, memory freeze,
// and saturating stall/flush event counters.
module id_ex_stage import id_ex_stage_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_stall,
  input  logic              ex_flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_inst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_rs1_data,
  input  logic [31:0]       id_rs2_data,
  input  logic [31:0]       id_imm,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_rs1_data,
  output logic [31:0]       ex_rs2_data,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              id_stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic hz;
  logic unused_inst_bits;

  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:12], id_inst[6:0]};

  load_use_detect u_lud (
    .id_valid    (id_valid),
    .rs1_use     (id_ctrl[CTRL_RS1USE]),
    .rs2_use     (id_ctrl[CTRL_RS2USE]),
    .rs1         (id_inst[19:15]),
    .rs2         (id_inst[24:20]),
    .ex_valid    (ex_valid),
    .ex_mem2reg  (ex_ctrl[CTRL_MEM2REG]),
    .ex_regwrite (ex_ctrl[CTRL_REGWRITE]),
    .ex_rd       (ex_rd),
    .hz          (hz)
  );

  // A flush already discards the ID instruction, so no front-end hold is needed then
  assign id_stall = hz && !ex_flush && !mem_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_ctrl     <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else if (mem_stall) begin
      ex_valid <= ex_valid;
    end else if (ex_flush || hz) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_ctrl     <= '0;
      if (ex_flush) begin
        if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end else begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rd       <= id_inst[11:7];
      ex_rs1      <= id_inst[19:15];
      ex_rs2      <= id_inst[24:20];
      ex_ctrl     <= id_valid ? id_ctrl : '0;
    end
  end
endmodule
